// File: rtl/ks_pkg.sv
// Shared constants and FSM state type for the sequential
// 75x75 carry-less Karatsuba multiplier.
package ks_pkg;

    localparam int KS_W      = 75;
    localparam int KS_SPLIT  = 64;
    localparam int KS_HI_W   = 11;
    localparam int KS_PROD_W = 149;

    typedef enum logic [2:0] {
        IDLE,
        MUL_L,
        MUL_H,
        MUL_M,
        DONE
    } ks_seq_state_t;

endpackage

// File: rtl/ks64.sv
// Combinational 64x64 -> 127 carry-less multiplier, one
// Karatsuba level over 32-bit halves.
module ks64 (
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic [126:0] p
);

    function automatic logic [62:0] clmul32(
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic [62:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) begin
                acc = acc ^ ({31'b0, x} << i);
            end
        end
        return acc;
    endfunction

    logic [62:0] lo;
    logic [62:0] hi;
    logic [62:0] mid;

    always_comb begin
        lo  = clmul32(a[31:0], b[31:0]);
        hi  = clmul32(a[63:32], b[63:32]);
        mid = clmul32(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32])
              ^ lo ^ hi;
        p   = {64'b0, lo}
              ^ ({64'b0, mid} << 32)
              ^ ({64'b0, hi} << 64);
    end

endmodule

// File: rtl/ks75_seq.sv
// Sequential 75x75 GF(2) multiplier: three sub-products of a
// 64/11 Karatsuba split time-share one ks64 core.
module ks75_seq
    import ks_pkg::*;
#(
    parameter int W = KS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [KS_PROD_W-1:0] d,
    output logic                 busy
);

    ks_seq_state_t state_q, state_d;

    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic [126:0]         m2_q, m2_d;
    logic [20:0]          m1_q, m1_d;
    logic [KS_PROD_W-1:0] d_q, d_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [63:0]  ks_a;
    logic [63:0]  ks_b;
    logic [126:0] ks_p;
    logic [126:0] mid;

    // Operand mux for the shared core, keyed on the current step.
    always_comb begin
        ks_a = a_q[KS_SPLIT-1:0];
        ks_b = b_q[KS_SPLIT-1:0];
        unique case (state_q)
            MUL_H: begin
                ks_a = {53'b0, a_q[W-1:KS_SPLIT]};
                ks_b = {53'b0, b_q[W-1:KS_SPLIT]};
            end
            MUL_M: begin
                ks_a = {a_q[63:KS_HI_W],
                        a_q[KS_HI_W-1:0] ^ a_q[W-1:KS_SPLIT]};
                ks_b = {b_q[63:KS_HI_W],
                        b_q[KS_HI_W-1:0] ^ b_q[W-1:KS_SPLIT]};
            end
            default: begin
                ks_a = a_q[KS_SPLIT-1:0];
                ks_b = b_q[KS_SPLIT-1:0];
            end
        endcase
    end

    ks64 u_ks64 (
        .a (ks_a),
        .b (ks_b),
        .p (ks_p)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m2_d    = m2_q;
        m1_d    = m1_q;
        d_d     = d_q;
        mid     = {106'b0, m1_q} ^ m2_q ^ ks_p;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = MUL_L;
                end
            end
            MUL_L: begin
                m2_d    = ks_p;
                state_d = MUL_H;
            end
            MUL_H: begin
                m1_d    = ks_p[20:0];
                state_d = MUL_M;
            end
            MUL_M: begin
                d_d = {22'b0, m2_q}
                      ^ ({22'b0, mid} << KS_SPLIT)
                      ^ ({128'b0, m1_q} << 128);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            m2_q        <= '0;
            m1_q        <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m2_q        <= m2_d;
            m1_q        <= m1_d;
            d_q         <= d_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign d         = d_q;

endmodule

// File: tb/tb_ks75_seq.sv
// Scoreboard bench for ks75_seq against a bit-serial
// carry-less reference product.
module tb_ks75_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [74:0]  a;
    logic [74:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [148:0] d;
    logic         busy;

    int nvec;
    int nerr;
    logic [148:0] exp_q[$];

    ks75_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [148:0] clmul_ref(
        input logic [74:0] x,
        input logic [74:0] y
    );
        logic [148:0] acc;
        acc = '0;
        for (int i = 0; i < 75; i++) begin
            if (y[i]) acc = acc ^ ({74'b0, x} << i);
        end
        return acc;
    endfunction

    // Presents one pair for a single cycle; returns at the
    // falling edge just after acceptance.
    task automatic launch(input logic [74:0] x,
                          input logic [74:0] y,
                          input logic [148:0] e,
                          input logic push);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL launch_wait in_ready=%b required=1",
                     in_ready);
            nerr++;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        int n;
        logic [148:0] e;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL %s_timeout out_valid=%b queued=%0d",
                     name, out_valid, exp_q.size());
            nerr++;
        end else begin
            e = exp_q.pop_front();
            if (d !== e) begin
                $display("FAIL %s_d got=%h required=%h",
                         name, d, e);
                nerr++;
            end
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL %s_dup out_valid=%b required=0",
                     name, out_valid);
            nerr++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        nvec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || d !== '0) begin
            $display("FAIL reset_outs got=%b%b%b d=%h required=100 d=0",
                     in_ready, out_valid, busy, d);
            nerr++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            $display("FAIL reset_release got=%b%b%b required=100",
                     in_ready, out_valid, busy);
            nerr++;
        end
    endtask

    task automatic test_basic();
        logic [148:0] e;
        out_ready = 1'b1;
        launch(75'd1, 75'd1, 149'd1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            nvec++;
            if (in_ready !== (k == 5) || out_valid !== (k == 4)) begin
                $display("FAIL basic_timing k=%0d in_ready=%b out_valid=%b required=%b %b",
                         k, in_ready, out_valid, k == 5, k == 4);
                nerr++;
            end
            if (k == 4 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                nvec++;
                if (d !== e) begin
                    $display("FAIL basic_d got=%h required=%h", d, e);
                    nerr++;
                end
            end
            if (k < 5) @(negedge clk);
        end
    endtask

    task automatic test_corners();
        logic [148:0] one;
        logic [74:0]  x;
        one = 149'd1;
        x = 75'd1;
        launch(x << 74, x << 74, one << 148, 1'b1);
        collect("hi_hi");
        launch(x << 74, x << 10, one << 84, 1'b1);
        collect("hi_mid");
        launch(x << 63, x << 11, one << 74, 1'b1);
        collect("split");
        launch(75'h5A5_A5A5_A5A5_A5A5_A5A5, 75'h7FF_0000_0000_0000_0001,
               clmul_ref(75'h5A5_A5A5_A5A5_A5A5_A5A5,
                         75'h7FF_0000_0000_0000_0001), 1'b1);
        collect("mixed");
    endtask

    task automatic test_stall();
        logic [148:0] e;
        out_ready = 1'b0;
        launch(75'h123_4567_89AB_CDEF_0123, 75'h7ED_CBA9_8765_4321_FEDC,
               clmul_ref(75'h123_4567_89AB_CDEF_0123,
                         75'h7ED_CBA9_8765_4321_FEDC), 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        a = 75'd6;
        b = 75'd7;
        in_valid = 1'b1;
        e = exp_q[0];
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (out_valid !== 1'b1 || d !== e || in_ready !== 1'b0) begin
                $display("FAIL stall_hold k=%0d ov=%b ir=%b d=%h required ov=1 ir=0 d=%h",
                         k, out_valid, in_ready, d, e);
                nerr++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL stall_release ir=%b ov=%b required=1 0",
                     in_ready, out_valid);
            nerr++;
        end
        exp_q.push_back(149'h12);
        @(negedge clk);
        in_valid = 1'b0;
        nvec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL stall_accept ir=%b busy=%b required=0 1",
                     in_ready, busy);
            nerr++;
        end
        collect("stall_next");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        launch(75'd5, 75'd7, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || d !== '0) begin
            $display("FAIL abort_outs got=%b%b%b d=%h required=100 d=0",
                     in_ready, out_valid, busy, d);
            nerr++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL abort_idle k=%0d ov=%b ir=%b required=0 1",
                         k, out_valid, in_ready);
                nerr++;
            end
        end
        launch(75'd3, 75'd3, 149'd5, 1'b1);
        collect("after_abort");
    endtask

    task automatic test_ones_busy();
        logic [74:0]  ones;
        logic [148:0] e;
        ones = '1;
        out_ready = 1'b1;
        launch(ones, 75'd1, {74'b0, ones}, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            nvec++;
            if (busy !== (k <= 4)) begin
                $display("FAIL busy_track k=%0d busy=%b required=%b",
                         k, busy, k <= 4);
                nerr++;
            end
            if (k == 4 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                nvec++;
                if (d !== e) begin
                    $display("FAIL ones_d got=%h required=%h", d, e);
                    nerr++;
                end
            end
            if (k < 5) @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [95:0]  ra;
        logic [95:0]  rb;
        logic [148:0] e;
        bit           got;
        for (int t = 0; t < 3000; t++) begin
            ra = {$urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom()};
            if (t % 7 == 0) ra = ra & (ra >> 3);
            out_ready = 1'b0;
            launch(ra[74:0], rb[74:0],
                   clmul_ref(ra[74:0], rb[74:0]), 1'b1);
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                if (out_valid) begin
                    e = exp_q[0];
                    nvec++;
                    if (d !== e) begin
                        $display("FAIL rand_d t=%0d got=%h required=%h",
                                 t, d, e);
                        nerr++;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got = 1'b1;
                    end
                end
                @(negedge clk);
            end
            nvec++;
            if (!got || out_valid !== 1'b0) begin
                $display("FAIL rand_handshake t=%0d got=%b ov=%b required=1 0",
                         t, got, out_valid);
                nerr++;
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_stall();
        test_reset_mid();
        test_ones_busy();
        test_random();
        nvec++;
        if (exp_q.size() != 0) begin
            $display("FAIL leftover queued=%0d required=0",
                     exp_q.size());
            nerr++;
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
